fma_write_buffer: RTL

Sits directly upstream of the data-cache memory block. Collects one result word from each FMA lane and packs them into a memory line. Queues completed lines in a small FIFO and presents the head line on write_buffer_read_out / write_buffer_valid_out until the consumer acknowledges it. The memory stores the line in BRAM with its LOADB instruction.

---
 rtl/gpu_pkg.sv | 17 +
 rtl/line_fifo.sv | 68 ++++++
 rtl/fma_write_buffer.sv | 93 +++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared constants and line layout for the FMA write buffer and the data-cache memory block.
// Word k of a line is numbered from the MSB; FMA i owns words 3i (a), 3i+1 (b), 3i+2 (c).
package gpu_pkg;

  localparam int FMA_COUNT  = 2;
  localparam int WORD_WIDTH = 16;
  localparam int LINE_WIDTH = FMA_COUNT * 3 * WORD_WIDTH;
  localparam int FWB_DEPTH  = 4;

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

  function automatic int word_lsb(input int k);
    return LINE_WIDTH - (k + 1) * WORD_WIDTH;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Synchronous DEPTH x LINE_WIDTH FIFO with a registered head output.
// A push while full only lands when a pop frees the slot in the same cycle.
module line_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = FWB_DEPTH
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push,
  input  line_t                      push_data,
  input  logic                       pop,
  output line_t                      head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  line_t          mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_next;
  logic           do_pop;
  logic           do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head mirrors mem[rd_ptr]; refreshed here so outputs stay registered.
      if (do_pop) begin
        if (count > CW'(1))   head <= mem[rd_next];
        else if (do_push)     head <= push_data;
        else                  head <= '0;
      end else if (empty && do_push) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/fma_write_buffer.sv
// Packs one result per FMA lane into a memory line (c slots) and queues completed lines.
// Optional FWB_PARTIAL_FLUSH_EN adds flush_in to push a partially captured line.
module fma_write_buffer
  import gpu_pkg::*;
#(
  parameter int DEPTH = FWB_DEPTH
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0]   fma_result_in,
  input  logic [FMA_COUNT-1:0]              fma_valid_in,
`ifdef FWB_PARTIAL_FLUSH_EN
  input  logic                              flush_in,
`endif
  output logic [LINE_WIDTH-1:0]             write_buffer_read_out,
  output logic                              write_buffer_valid_out,
  input  logic                              write_buffer_ack_in,
  output logic [$clog2(DEPTH+1)-1:0]        count_out,
  output logic                              lane_conflict_out,
  output logic                              overflow_out
);

  // Handshake: the head line is offered while write_buffer_valid_out is high and
  // held stable until write_buffer_ack_in is seen at a clock edge, which pops it.

  logic [FMA_COUNT-1:0] mask;
  logic [FMA_COUNT-1:0] accept;
  logic [FMA_COUNT-1:0] next_mask;
  word_t                cap [FMA_COUNT];
  word_t                lane_word [FMA_COUNT];
  line_t                packed_line;
  logic                 flush_go;
  logic                 push_line;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_dropped;
  line_t                fifo_head;

  assign accept    = fma_valid_in & ~mask;
  assign next_mask = mask | accept;

`ifdef FWB_PARTIAL_FLUSH_EN
  assign flush_go = flush_in && (mask != '0);
`else
  assign flush_go = 1'b0;
`endif

  assign push_line = (&next_mask) | flush_go;

  // Lanes not yet captured contribute zero, which matters for partial flushes.
  always_comb begin
    packed_line = '0;
    for (int i = 0; i < FMA_COUNT; i++) begin
      lane_word[i] = '0;
      if (accept[i])    lane_word[i] = fma_result_in[i*WORD_WIDTH +: WORD_WIDTH];
      else if (mask[i]) lane_word[i] = cap[i];
      packed_line[word_lsb(3*i+2) +: WORD_WIDTH] = lane_word[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mask              <= '0;
      lane_conflict_out <= 1'b0;
      overflow_out      <= 1'b0;
      for (int i = 0; i < FMA_COUNT; i++) cap[i] <= '0;
    end else begin
      if (|(fma_valid_in & mask)) lane_conflict_out <= 1'b1;
      if (fifo_dropped)           overflow_out      <= 1'b1;
      mask <= push_line ? '0 : next_mask;
      for (int i = 0; i < FMA_COUNT; i++) begin
        if (accept[i]) cap[i] <= fma_result_in[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  line_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push_line),
    .push_data (packed_line),
    .pop       (write_buffer_ack_in),
    .head      (fifo_head),
    .count     (count_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  assign write_buffer_read_out  = fifo_head;
  assign write_buffer_valid_out = ~fifo_empty;

endmodule
